alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
- Registered instruction decoder for the integer ALU path.
- Classifies a 32-bit instruction word into a kind (RRR, RRI, none, invalid).
- Produces the ALU control word: core op, lhs/rhs unary pre-ops, rhs shifter spec and result unary post-op.
- Sits between fetch and the execute-stage ALU.
- SUB is expressed as ADD with negated rhs; OR is expressed as NOT(NOT a AND NOT b).

Parameters:
- None. All encodings are fixed.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction word is valid this cycle.
- instruction  input  32  instruction word.
- kind  output  2  e_kind: KIND_NONE=0, KIND_RRR=1, KIND_RRI=2, KIND_INVALID=3.
- control  output  17  s_control = {core_op[16:13], lhs_op[12:11], rhs_op[10:9], shift_kind[8:7], shift_amt[6:2], out_op[1:0]}.
- ctrl_valid  output  1  control describes a valid ALU operation.

Behaviour:
- Encodings:
  - core_op: CORE_OP_ADD=0, AND=1, XOR=2, SHL=3, SHR=4, ASL=5, ASR=6, ROL=7, ROR=8; values 9-15 are never emitted.
  - unary op: UNARY_OP_ID=0, NEG=1, NOT=2; value 3 is never emitted.
  - shift_kind: SHIFT_SHL=0, SHR=1, ASR=2, ROR=3.
- Default control word is all zeros, i.e. {ADD, ID, ID, {SHL, 5'b0}, ID}.
- Instruction format:
  - [31:30] format: 00 = RRR, 01 = RRI, 1x = non-ALU.
  - [29:26] func: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 asl, 8 asr, 9 rol, 10 ror; 11-15 are reserved.
  - [25:21] rd, [20:16] rs1.
  - RRR only: [15:11] rs2, [10:9] rhs shift_kind, [8:4] rhs shift_amt, [3:0] ignored.
  - RRI only: [15:0] immediate; operand fields are not decoded here.
- Kind classification:
  - format 00 with func <= 10 -> KIND_RRR.
  - format 01 with func <= 10 -> KIND_RRI.
  - format 1x -> KIND_NONE.
  - format 0x with func >= 11 -> KIND_INVALID.
- Function to control mapping (core, lhs, rhs, out):
  - add: ADD, ID, ID, ID.
  - sub: ADD, ID, NEG, ID.
  - and: AND, ID, ID, ID.
  - or: AND, NOT, NOT, NOT.
  - xor: XOR, ID, ID, ID.
  - shl/shr/asl/asr/rol/ror: matching CORE_OP, ID, ID, ID.
- Shift field:
  - RRR: copied from [10:9] and [8:4].
  - RRI: forced to {SHL, 0}.
- Non-ALU kinds (NONE, INVALID): control = default and ctrl_valid = 0.
- ALU kinds: ctrl_valid = 1.
- instr_valid = 0: the next registered state is KIND_NONE, default control and ctrl_valid = 0, regardless of the instruction value.
- Latency: decode is combinational and registered once. Outputs reflect the instruction sampled at the previous rising clk edge (1-cycle latency). A new instruction is accepted every cycle; there is no backpressure.
- Reset: while rst_n = 0, and immediately on assertion (asynchronous):
  - kind = KIND_NONE, control = 17'b0, ctrl_valid = 0.
  - Deassertion takes effect synchronously; the first decode appears one edge after the first sampling edge with rst_n = 1.
  - Reset mid-stream discards the in-flight decode.
- All outputs are driven from flops; there are no combinational input-to-output paths.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with instruction = add RRR -> kind = 0, control = 17'h0, ctrl_valid = 0 immediately; release -> add decode appears after 1 edge.
- RRR sweep: add, sub, and, or, xor, shl, shr, asl, asr, rol, ror, all with r0, r1, r2 and shift field 0. Expect KIND_RRR, ctrl_valid = 1, and control per the mapping. In particular:
  - sub = {ADD, ID, NEG, {SHL, 0}, ID}.
  - or = {AND, NOT, NOT, {SHL, 0}, NOT}.
  - rol = {ROL, ID, ID, {SHL, 0}, ID}.
- RRR shift field: xor with [10:9] = 2 and [8:4] = 5'd7 -> control = {XOR, ID, ID, {ASR, 7}, ID}.
- RRI: sub immediate with [10:4] nonzero -> KIND_RRI, control = {ADD, ID, NEG, {SHL, 0}, ID}.
- Invalid/non-ALU cases, each expecting control = 0 and ctrl_valid = 0:
  - format 00 with func 13 -> KIND_INVALID.
  - format 10 -> KIND_NONE.
  - instr_valid = 0 with a valid add word -> KIND_NONE.
- Back-to-back stream: add, or, ror on consecutive cycles -> outputs match each instruction exactly one cycle later, with no bubbles.

Source files
------------

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered decoder from a 32-bit instruction word to an
// instruction kind and the integer ALU control word.
// Subtraction is ADD with a negated rhs; OR is NOT(NOT a AND NOT b).
// The decode is combinational and is registered once, so outputs have a
// latency of one cycle.
module alu_op_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic [1:0]  kind,
    output logic [16:0] control,
    output logic        ctrl_valid
);

    // Instruction kinds
    localparam logic [1:0] KIND_NONE    = 2'd0;
    localparam logic [1:0] KIND_RRR     = 2'd1;
    localparam logic [1:0] KIND_RRI     = 2'd2;
    localparam logic [1:0] KIND_INVALID = 2'd3;

    // Core ALU operations
    localparam logic [3:0] CORE_OP_ADD = 4'd0;
    localparam logic [3:0] CORE_OP_AND = 4'd1;
    localparam logic [3:0] CORE_OP_XOR = 4'd2;
    localparam logic [3:0] CORE_OP_SHL = 4'd3;
    localparam logic [3:0] CORE_OP_SHR = 4'd4;
    localparam logic [3:0] CORE_OP_ASL = 4'd5;
    localparam logic [3:0] CORE_OP_ASR = 4'd6;
    localparam logic [3:0] CORE_OP_ROL = 4'd7;
    localparam logic [3:0] CORE_OP_ROR = 4'd8;

    // Unary pre/post operations
    localparam logic [1:0] UNARY_OP_ID  = 2'd0;
    localparam logic [1:0] UNARY_OP_NEG = 2'd1;
    localparam logic [1:0] UNARY_OP_NOT = 2'd2;

    // Shifter kinds
    localparam logic [1:0] SHIFT_SHL = 2'd0;

    // Function codes; 11..15 are reserved
    localparam logic [3:0] FUNC_ADD = 4'd0;
    localparam logic [3:0] FUNC_SUB = 4'd1;
    localparam logic [3:0] FUNC_AND = 4'd2;
    localparam logic [3:0] FUNC_OR  = 4'd3;
    localparam logic [3:0] FUNC_XOR = 4'd4;
    localparam logic [3:0] FUNC_SHL = 4'd5;
    localparam logic [3:0] FUNC_SHR = 4'd6;
    localparam logic [3:0] FUNC_ASL = 4'd7;
    localparam logic [3:0] FUNC_ASR = 4'd8;
    localparam logic [3:0] FUNC_ROL = 4'd9;
    localparam logic [3:0] FUNC_ROR = 4'd10;

    // Pack the control word fields in their fixed bit order.
    function automatic logic [16:0] pack_control(
        input logic [3:0] core_op,
        input logic [1:0] lhs_op,
        input logic [1:0] rhs_op,
        input logic [1:0] shift_kind,
        input logic [4:0] shift_amt,
        input logic [1:0] out_op
    );
        pack_control = {core_op, lhs_op, rhs_op, shift_kind, shift_amt, out_op};
    endfunction

    logic [1:0]  format_s;
    logic [3:0]  func_s;
    logic [1:0]  rrr_shift_kind_s;
    logic [4:0]  rrr_shift_amt_s;
    logic [3:0]  core_op_s;
    logic [1:0]  lhs_op_s;
    logic [1:0]  rhs_op_s;
    logic [1:0]  out_op_s;
    logic [1:0]  shift_kind_s;
    logic [4:0]  shift_amt_s;
    logic [1:0]  kind_s;
    logic [16:0] control_s;
    logic        ctrl_valid_s;

    logic [1:0]  kind_r;
    logic [16:0] control_r;
    logic        ctrl_valid_r;

    assign format_s         = instruction[31:30];
    assign func_s           = instruction[29:26];
    assign rrr_shift_kind_s = instruction[10:9];
    assign rrr_shift_amt_s  = instruction[8:4];

    // Map the function code to core op and unary pre/post ops.
    always_comb begin
        core_op_s = CORE_OP_ADD;
        lhs_op_s  = UNARY_OP_ID;
        rhs_op_s  = UNARY_OP_ID;
        out_op_s  = UNARY_OP_ID;
        case (func_s)
            FUNC_ADD: core_op_s = CORE_OP_ADD;
            FUNC_SUB: begin
                core_op_s = CORE_OP_ADD;
                rhs_op_s  = UNARY_OP_NEG;
            end
            FUNC_AND: core_op_s = CORE_OP_AND;
            FUNC_OR: begin
                core_op_s = CORE_OP_AND;
                lhs_op_s  = UNARY_OP_NOT;
                rhs_op_s  = UNARY_OP_NOT;
                out_op_s  = UNARY_OP_NOT;
            end
            FUNC_XOR: core_op_s = CORE_OP_XOR;
            FUNC_SHL: core_op_s = CORE_OP_SHL;
            FUNC_SHR: core_op_s = CORE_OP_SHR;
            FUNC_ASL: core_op_s = CORE_OP_ASL;
            FUNC_ASR: core_op_s = CORE_OP_ASR;
            FUNC_ROL: core_op_s = CORE_OP_ROL;
            FUNC_ROR: core_op_s = CORE_OP_ROR;
            default:  core_op_s = CORE_OP_ADD;
        endcase
    end

    // Only register-register forms carry a shifter spec; immediates get none.
    always_comb begin
        shift_kind_s = SHIFT_SHL;
        shift_amt_s  = 5'd0;
        if (format_s == 2'b00) begin
            shift_kind_s = rrr_shift_kind_s;
            shift_amt_s  = rrr_shift_amt_s;
        end else begin
            shift_kind_s = SHIFT_SHL;
            shift_amt_s  = 5'd0;
        end
    end

    // Classify the word; non-ALU kinds and idle cycles yield the default word.
    always_comb begin
        kind_s       = KIND_NONE;
        control_s    = 17'd0;
        ctrl_valid_s = 1'b0;
        if (!instr_valid) begin
            kind_s = KIND_NONE;
        end else if (format_s[1]) begin
            kind_s = KIND_NONE;
        end else if (func_s > FUNC_ROR) begin
            kind_s = KIND_INVALID;
        end else begin
            kind_s       = format_s[0] ? KIND_RRI : KIND_RRR;
            control_s    = pack_control(core_op_s, lhs_op_s, rhs_op_s,
                                        shift_kind_s, shift_amt_s, out_op_s);
            ctrl_valid_s = 1'b1;
        end
    end

    // Output register; reset clears the in-flight decode immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_r       <= KIND_NONE;
            control_r    <= 17'd0;
            ctrl_valid_r <= 1'b0;
        end else begin
            kind_r       <= kind_s;
            control_r    <= control_s;
            ctrl_valid_r <= ctrl_valid_s;
        end
    end

    assign kind       = kind_r;
    assign control    = control_r;
    assign ctrl_valid = ctrl_valid_r;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed, table-driven bench for alu_op_decoder.
module tb_alu_op_decoder;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_RRR  = 2'd1;
    localparam logic [1:0] K_RRI  = 2'd2;
    localparam logic [1:0] K_INV  = 2'd3;

    localparam logic [3:0] C_ADD = 4'd0;
    localparam logic [3:0] C_AND = 4'd1;
    localparam logic [3:0] C_XOR = 4'd2;
    localparam logic [3:0] C_SHL = 4'd3;
    localparam logic [3:0] C_SHR = 4'd4;
    localparam logic [3:0] C_ASL = 4'd5;
    localparam logic [3:0] C_ASR = 4'd6;
    localparam logic [3:0] C_ROL = 4'd7;
    localparam logic [3:0] C_ROR = 4'd8;

    localparam logic [1:0] U_ID  = 2'd0;
    localparam logic [1:0] U_NEG = 2'd1;
    localparam logic [1:0] U_NOT = 2'd2;

    localparam logic [1:0] S_SHL = 2'd0;
    localparam logic [1:0] S_ASR = 2'd2;
    localparam logic [1:0] S_ROR = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [1:0]  kind;
        logic [16:0] ctrl;
        logic        cv;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [1:0]  kind;
    logic [16:0] control;
    logic        ctrl_valid;

    int n_checks;
    int n_fail;

    vec_t vecs[20];
    int   n_vecs;

    alu_op_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .kind        (kind),
        .control     (control),
        .ctrl_valid  (ctrl_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rrr(input logic [3:0] func, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [1:0] sk, input logic [4:0] sa);
        rrr = {2'b00, func, rd, rs1, rs2, sk, sa, 4'b0000};
    endfunction

    function automatic logic [31:0] rri(input logic [3:0] func, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
        rri = {2'b01, func, rd, rs1, imm};
    endfunction

    function automatic logic [16:0] ctl(input logic [3:0] c, input logic [1:0] l,
                                        input logic [1:0] r, input logic [1:0] sk,
                                        input logic [4:0] sa, input logic [1:0] o);
        ctl = {c, l, r, sk, sa, o};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] i, input logic [1:0] k,
                                input logic [16:0] c, input logic cv);
        mk = '{valid: v, instr: i, kind: k, ctrl: c, cv: cv};
    endfunction

    task automatic check(input string name, input logic [1:0] ek,
                         input logic [16:0] ec, input logic ev);
        n_checks++;
        if (kind !== ek) begin
            n_fail++;
            $display("FAIL %s kind: got %0d expected %0d", name, kind, ek);
        end
        n_checks++;
        if (control !== ec) begin
            n_fail++;
            $display("FAIL %s control: got 17'h%05h expected 17'h%05h", name, control, ec);
        end
        n_checks++;
        if (ctrl_valid !== ev) begin
            n_fail++;
            $display("FAIL %s ctrl_valid: got %0b expected %0b", name, ctrl_valid, ev);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // RRR sweep r0 <- r1 op r2, shift field 0
        vecs[0]  = mk(1'b1, rrr(4'd0,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_ADD, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[1]  = mk(1'b1, rrr(4'd1,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_ADD, U_ID,  U_NEG, S_SHL, 5'd0, U_ID),  1'b1);
        vecs[2]  = mk(1'b1, rrr(4'd2,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_AND, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[3]  = mk(1'b1, rrr(4'd3,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_AND, U_NOT, U_NOT, S_SHL, 5'd0, U_NOT), 1'b1);
        vecs[4]  = mk(1'b1, rrr(4'd4,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_XOR, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[5]  = mk(1'b1, rrr(4'd5,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_SHL, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[6]  = mk(1'b1, rrr(4'd6,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_SHR, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[7]  = mk(1'b1, rrr(4'd7,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_ASL, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[8]  = mk(1'b1, rrr(4'd8,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_ASR, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[9]  = mk(1'b1, rrr(4'd9,  5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_ROL, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        vecs[10] = mk(1'b1, rrr(4'd10, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0), K_RRR, ctl(C_ROR, U_ID,  U_ID,  S_SHL, 5'd0, U_ID),  1'b1);
        // RRR shift field carried through: xor with ASR by 7, and ror with ROR by 31
        vecs[11] = mk(1'b1, rrr(4'd4,  5'd3, 5'd4, 5'd5, 2'd2, 5'd7),  K_RRR, ctl(C_XOR, U_ID, U_ID, S_ASR, 5'd7,  U_ID), 1'b1);
        vecs[12] = mk(1'b1, rrr(4'd10, 5'd3, 5'd4, 5'd5, 2'd3, 5'd31), K_RRR, ctl(C_ROR, U_ID, U_ID, S_ROR, 5'd31, U_ID), 1'b1);
        // RRI: shift field forced to zero regardless of immediate bits
        vecs[13] = mk(1'b1, rri(4'd1,  5'd6, 5'd7, 16'h07F0), K_RRI, ctl(C_ADD, U_ID, U_NEG, S_SHL, 5'd0, U_ID), 1'b1);
        vecs[14] = mk(1'b1, rri(4'd10, 5'd6, 5'd7, 16'hFFFF), K_RRI, ctl(C_ROR, U_ID, U_ID,  S_SHL, 5'd0, U_ID), 1'b1);
        // Invalid / non-ALU words
        vecs[15] = mk(1'b1, {2'b00, 4'd13, 26'h3FF_FFFF}, K_INV,  17'd0, 1'b0);
        vecs[16] = mk(1'b1, {2'b01, 4'd11, 26'h000_0FF0}, K_INV,  17'd0, 1'b0);
        vecs[17] = mk(1'b1, {2'b10, 4'd0,  26'h000_1220}, K_NONE, 17'd0, 1'b0);
        vecs[18] = mk(1'b1, {2'b11, 4'd3,  26'h155_5555}, K_NONE, 17'd0, 1'b0);
        // Not valid: a legal add word must be ignored
        vecs[19] = mk(1'b0, rrr(4'd0, 5'd0, 5'd1, 5'd2, 2'd1, 5'd9), K_NONE, 17'd0, 1'b0);
        n_vecs = 20;

        // Reset state before any clock edge
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instruction = rrr(4'd0, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0);
        #2;
        check("reset_initial", K_NONE, 17'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", K_NONE, 17'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table sweep, one vector per cycle
        for (int i = 0; i < n_vecs; i++) begin
            @(negedge clk);
            instr_valid = vecs[i].valid;
            instruction = vecs[i].instr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].kind, vecs[i].ctrl, vecs[i].cv);
        end

        // Latency: output must not change before the next edge
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = rrr(4'd3, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0);
        #1;
        check("latency_hold", K_NONE, 17'd0, 1'b0);
        @(posedge clk);
        #1;
        check("latency_or", K_RRR, ctl(C_AND, U_NOT, U_NOT, S_SHL, 5'd0, U_NOT), 1'b1);

        // Back-to-back stream, inputs changed right after each sampling edge
        instruction = rrr(4'd0, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0);
        @(posedge clk);
        #1;
        check("b2b_add", K_RRR, ctl(C_ADD, U_ID, U_ID, S_SHL, 5'd0, U_ID), 1'b1);
        instruction = rrr(4'd3, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0);
        @(posedge clk);
        #1;
        check("b2b_or", K_RRR, ctl(C_AND, U_NOT, U_NOT, S_SHL, 5'd0, U_NOT), 1'b1);
        instruction = rrr(4'd10, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0);
        @(posedge clk);
        #1;
        check("b2b_ror", K_RRR, ctl(C_ROR, U_ID, U_ID, S_SHL, 5'd0, U_ID), 1'b1);

        // Mid-stream asynchronous reset with an add word on the input
        instruction = rrr(4'd0, 5'd0, 5'd1, 5'd2, 2'd0, 5'd0);
        @(posedge clk);
        #1;
        check("pre_reset_add", K_RRR, 17'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", K_NONE, 17'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_edge", K_NONE, 17'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", K_NONE, 17'd0, 1'b0);
        @(posedge clk);
        #1;
        check("release_add", K_RRR, 17'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
